// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {ARB, LOCKED} arb_state_e;
    typedef logic req_id_t;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    function automatic logic [1:0] onehot(req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, response and memory-side signals of the arbiter.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF,
    parameter int DATA_WIDTH = DATA_W_DEF
);
    logic [1:0]              rq_valid;
    logic [1:0]              rq_ready;
    logic [1:0]              rq_we;
    logic [1:0]              rq_lock;
    logic [2*ADDR_WIDTH-1:0] rq_addr;
    logic [2*DATA_WIDTH-1:0] rq_wdata;
    logic [1:0]              rs_valid;
    logic [DATA_WIDTH-1:0]   rs_rdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        output rq_valid, rq_we, rq_lock, rq_addr, rq_wdata, mem_rdata,
        input  rq_ready, rs_valid, rs_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rq_valid, rq_we, rq_lock, rq_addr, rq_wdata, mem_rdata,
        output rq_ready, rs_valid, rs_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_rr_grant2.sv
// rr_grant2: combinational 2-way round-robin picker with owner override.
module rr_grant2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    input  logic       force_owner_en,
    input  req_id_t    owner,
    output logic [1:0] grant
);
    always_comb grant = force_owner_en ? onehot(owner) : (&req) ? onehot(~last_grant) : req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port memory between two
// requesters, with burst lock, lock watchdog and tagged read-data return.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_W_DEF,
    parameter int DATA_WIDTH     = DATA_W_DEF,
    parameter int RD_LATENCY     = 1,
    parameter int MAX_LOCK_BEATS = 16
)(
    input logic              ACLK,
    input logic              ARESET,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_LOCK_BEATS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK_BEATS);

    arb_state_e            state;
    req_id_t               last_grant;
    req_id_t               owner;
    logic [CW-1:0]         beat_cnt;
    logic [1:0]            pick;
    logic [1:0]            grant;
    req_id_t               win;
    logic                  accept;
    logic                  lock_bit;
    logic                  rd_acc;
    logic [RD_LATENCY-1:0] pv;
    req_id_t               pid [RD_LATENCY];
    logic                  rsp;
    logic [DATA_WIDTH-1:0] rdata_q;

    rr_grant2 u_pick (
        .req            (bus.rq_valid),
        .last_grant     (last_grant),
        .force_owner_en (state == LOCKED),
        .owner          (owner),
        .grant          (pick)
    );

    // Nothing is granted while reset is held so no beat slips through.
    assign grant        = ARESET ? 2'b00 : pick;
    assign win          = grant[1];
    assign accept       = |(grant & bus.rq_valid);
    assign lock_bit     = win ? bus.rq_lock[1] : bus.rq_lock[0];
    assign rd_acc       = accept & ~bus.mem_we;
    assign bus.rq_ready = grant;
    assign bus.mem_en   = accept;
    assign bus.mem_we   = accept & (win ? bus.rq_we[1] : bus.rq_we[0]);
    assign bus.mem_addr = !accept ? '0 : win ? bus.rq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.rq_addr[ADDR_WIDTH-1:0];
    assign bus.mem_wdata = !accept ? '0 : win ? bus.rq_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : bus.rq_wdata[DATA_WIDTH-1:0];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= ARB;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            beat_cnt   <= '0;
        end else if (accept) begin
            last_grant <= win;
            if (state == ARB) begin
                if (lock_bit) begin
                    state    <= LOCKED;
                    owner    <= win;
                    beat_cnt <= CW'(1);
                end
            end else if (!lock_bit || beat_cnt + 1'b1 == MAX_CNT) begin
                state    <= ARB;
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pv <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pid[i] <= 1'b0;
        end else begin
            pv[0]  <= rd_acc;
            pid[0] <= win;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i]  <= pv[i-1];
                pid[i] <= pid[i-1];
            end
        end
    end

    // A response still in the pipe when reset arrives is suppressed.
    assign rsp          = pv[RD_LATENCY-1] & ~ARESET;
    assign bus.rs_valid = rsp ? onehot(pid[RD_LATENCY-1]) : 2'b00;
    assign bus.rs_rdata = rsp ? bus.mem_rdata : rdata_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) rdata_q <= '0;
        else        rdata_q <= bus.rs_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, locking, watchdog, reset and read return.
module tb_mem_port_arbiter;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .RD_LATENCY     (LAT),
        .MAX_LOCK_BEATS (16)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten words read as 0xA5000000 | addr, idle cycles return junk.
    logic [DW-1:0] mem [1024];
    bit   [1023:0] written;
    logic [DW-1:0] rd [LAT];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr]     <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
        end
        rd[0] <= (bus.mem_en && !bus.mem_we) ?
                 (written[bus.mem_addr] ? mem[bus.mem_addr] : (32'hA500_0000 | 32'(bus.mem_addr))) :
                 32'h0BAD_0BAD;
        for (int i = 1; i < LAT; i++) rd[i] <= rd[i-1];
    end
    assign bus.mem_rdata = rd[LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic set_rq(input int i, input logic v, input logic we, input logic lk,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.rq_valid[i]          = v;
        bus.rq_we[i]             = we;
        bus.rq_lock[i]           = lk;
        bus.rq_addr[i*AW +: AW]  = a;
        bus.rq_wdata[i*DW +: DW] = d;
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy"}, 64'(bus.rq_ready), 64'd0);
        check({tag, "_rsv"}, 64'(bus.rs_valid), 64'd0);
        check({tag, "_en"},  64'(bus.mem_en), 64'd0);
        check({tag, "_we"},  64'(bus.mem_we), 64'd0);
        check({tag, "_adr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_wd"},  64'(bus.mem_wdata), 64'd0);
    endtask

    initial begin
        logic [1:0]  exp_rs;
        logic [31:0] exp_d;
        int n0, n1, c0, c1, nb;

        set_rq(0, 1, 0, 0, 10'h005, 0);
        set_rq(1, 1, 0, 0, 10'h006, 0);
        smp();
        check_idle("rst");
        nx();
        rst = 1'b0;

        set_rq(0, 1, 1, 0, 10'h005, 32'hDEAD_BEEF);
        set_rq(1, 0, 0, 0, 0, 0);
        smp();
        check("t1_wr_rdy", 64'(bus.rq_ready), 64'h1);
        check("t1_wr_en", 64'(bus.mem_en), 64'h1);
        check("t1_wr_we", 64'(bus.mem_we), 64'h1);
        check("t1_wr_adr", 64'(bus.mem_addr), 64'h005);
        check("t1_wr_wd", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
        nx();
        set_rq(0, 1, 0, 0, 10'h005, 0);
        smp();
        check("t1_rd_rdy", 64'(bus.rq_ready), 64'h1);
        check("t1_rd_we", 64'(bus.mem_we), 64'h0);
        check("t1_rd_rsv", 64'(bus.rs_valid), 64'h0);
        nx();
        set_rq(0, 0, 0, 0, 0, 0);
        set_rq(1, 1, 1, 0, 10'h3FF, 32'hCAFE_03FF);
        smp();
        check("t1_rsv", 64'(bus.rs_valid), 64'h1);
        check("t1_rsd", 64'(bus.rs_rdata), 64'hDEAD_BEEF);
        check("t1_r1_rdy", 64'(bus.rq_ready), 64'h2);
        check("t1_r1_adr", 64'(bus.mem_addr), 64'h3FF);
        nx();
        set_rq(1, 0, 0, 0, 0, 0);
        smp();
        check("t1_hold_rsv", 64'(bus.rs_valid), 64'h0);
        check("t1_hold_rsd", 64'(bus.rs_rdata), 64'hDEAD_BEEF);
        check("t1_idle_en", 64'(bus.mem_en), 64'h0);
        check("t1_idle_adr", 64'(bus.mem_addr), 64'h0);
        nx();

        // Requester 1 was served last, so contention starts with requester 0.
        exp_rs = 2'b00; exp_d = 0; n0 = 0; n1 = 0; c0 = 0; c1 = 0;
        for (int k = 0; k < 8; k++) begin
            set_rq(0, 1, 0, 0, 10'(10'h100 + n0), 0);
            set_rq(1, 1, 0, 0, 10'(10'h200 + n1), 0);
            smp();
            check("t2_rdy", 64'(bus.rq_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            check("t2_rsv", 64'(bus.rs_valid), 64'(exp_rs));
            if (exp_rs != 2'b00) check("t2_rsd", 64'(bus.rs_rdata), 64'(exp_d));
            c0 += int'(bus.rs_valid[0]);
            c1 += int'(bus.rs_valid[1]);
            if (k % 2 == 0) begin
                exp_rs = 2'b01; exp_d = 32'hA500_0100 + 32'(n0); n0++;
            end else begin
                exp_rs = 2'b10; exp_d = 32'hA500_0200 + 32'(n1); n1++;
            end
            nx();
        end
        set_rq(0, 0, 0, 0, 0, 0);
        set_rq(1, 0, 0, 0, 0, 0);
        smp();
        check("t2_last_rsv", 64'(bus.rs_valid), 64'(exp_rs));
        check("t2_last_rsd", 64'(bus.rs_rdata), 64'(exp_d));
        c0 += int'(bus.rs_valid[0]);
        c1 += int'(bus.rs_valid[1]);
        check("t2_cnt0", 64'(c0), 64'd4);
        check("t2_cnt1", 64'(c1), 64'd4);
        nx();

        set_rq(0, 1, 0, 0, 10'h005, 0);
        set_rq(1, 1, 1, 1, 10'h040, 32'hB000_0040);
        smp();
        check("t3_c0_rdy", 64'(bus.rq_ready), 64'h1);
        nx();
        set_rq(0, 1, 0, 0, 10'h006, 0);
        smp();
        check("t3_b1_rdy", 64'(bus.rq_ready), 64'h2);
        check("t3_b1_rsv", 64'(bus.rs_valid), 64'h1);
        check("t3_b1_rsd", 64'(bus.rs_rdata), 64'hDEAD_BEEF);
        nx();
        set_rq(1, 1, 1, 1, 10'h041, 32'hB000_0041);
        smp();
        check("t3_b2_rdy", 64'(bus.rq_ready), 64'h2);
        check("t3_b2_adr", 64'(bus.mem_addr), 64'h041);
        nx();
        set_rq(1, 0, 1, 1, 10'h041, 32'hB000_0041);
        smp();
        check("t3_bub_rdy", 64'(bus.rq_ready), 64'h2);
        check("t3_bub_en", 64'(bus.mem_en), 64'h0);
        nx();
        set_rq(1, 1, 1, 1, 10'h042, 32'hB000_0042);
        smp();
        check("t3_b3_rdy", 64'(bus.rq_ready), 64'h2);
        nx();
        set_rq(1, 1, 1, 0, 10'h043, 32'hB000_0043);
        smp();
        check("t3_b4_rdy", 64'(bus.rq_ready), 64'h2);
        check("t3_b4_we", 64'(bus.mem_we), 64'h1);
        nx();
        set_rq(1, 1, 0, 0, 10'h040, 0);
        smp();
        check("t3_after_rdy", 64'(bus.rq_ready), 64'h1);
        nx();
        set_rq(0, 0, 0, 0, 0, 0);
        smp();
        check("t3_r1_rdy", 64'(bus.rq_ready), 64'h2);
        check("t3_r0_rsv", 64'(bus.rs_valid), 64'h1);
        check("t3_r0_rsd", 64'(bus.rs_rdata), 64'hA500_0006);
        nx();
        set_rq(1, 0, 0, 0, 0, 0);
        smp();
        check("t3_r1_rsv", 64'(bus.rs_valid), 64'h2);
        check("t3_r1_rsd", 64'(bus.rs_rdata), 64'hB000_0040);
        nx();

        // 16 locked beats, one forced beat for requester 1, then 4 more locked beats.
        nb = 0;
        set_rq(1, 1, 0, 0, 10'h043, 0);
        for (int k = 0; k < 21; k++) begin
            set_rq(0, 1, 1, 1, 10'(10'h080 + nb), 32'hC000_0000 + 32'(nb));
            smp();
            check("t4_rdy", 64'(bus.rq_ready), (k == 16) ? 64'h2 : 64'h1);
            check("t4_we", 64'(bus.mem_we), (k == 16) ? 64'h0 : 64'h1);
            if (k == 17) begin
                check("t4_rsv", 64'(bus.rs_valid), 64'h2);
                check("t4_rsd", 64'(bus.rs_rdata), 64'hB000_0043);
            end
            if (k != 16) nb++;
            nx();
        end
        set_rq(0, 0, 0, 0, 0, 0);
        smp();
        check("t4_own_idle_rdy", 64'(bus.rq_ready), 64'h1);
        check("t4_own_idle_en", 64'(bus.mem_en), 64'h0);
        nx();

        set_rq(0, 1, 0, 1, 10'h3FF, 0);
        set_rq(1, 0, 0, 0, 0, 0);
        smp();
        check("t5_a_rdy", 64'(bus.rq_ready), 64'h1);
        nx();
        rst = 1'b1;
        set_rq(0, 1, 0, 0, 10'h005, 0);
        set_rq(1, 1, 0, 0, 10'h005, 0);
        smp();
        check_idle("t5_rst");
        nx();
        rst = 1'b0;
        set_rq(0, 0, 0, 0, 0, 0);
        set_rq(1, 1, 0, 0, 10'h3FF, 0);
        smp();
        check("t5_c_rdy", 64'(bus.rq_ready), 64'h2);
        check("t5_c_rsv", 64'(bus.rs_valid), 64'h0);
        nx();
        rst = 1'b1;
        set_rq(1, 0, 0, 0, 0, 0);
        smp();
        check("t5_d_rsv", 64'(bus.rs_valid), 64'h0);
        check("t5_d_rdy", 64'(bus.rq_ready), 64'h0);
        nx();
        rst = 1'b0;

        set_rq(0, 1, 1, 0, 10'h000, 32'h0000_F00D);
        set_rq(1, 1, 1, 0, 10'h3FF, 32'hFFFF_1234);
        smp();
        check("t6_e_rdy", 64'(bus.rq_ready), 64'h1);
        check("t6_e_rsv", 64'(bus.rs_valid), 64'h0);
        check("t6_e_we", 64'(bus.mem_we), 64'h1);
        check("t6_e_adr", 64'(bus.mem_addr), 64'h000);
        check("t6_e_wd", 64'(bus.mem_wdata), 64'h0000_F00D);
        nx();
        set_rq(0, 1, 0, 0, 10'h3FF, 0);
        smp();
        check("t6_f_rdy", 64'(bus.rq_ready), 64'h2);
        check("t6_f_adr", 64'(bus.mem_addr), 64'h3FF);
        check("t6_f_wd", 64'(bus.mem_wdata), 64'hFFFF_1234);
        nx();
        set_rq(1, 1, 0, 0, 10'h000, 0);
        smp();
        check("t6_g_rdy", 64'(bus.rq_ready), 64'h1);
        check("t6_g_we", 64'(bus.mem_we), 64'h0);
        check("t6_g_adr", 64'(bus.mem_addr), 64'h3FF);
        nx();
        set_rq(0, 0, 0, 0, 0, 0);
        smp();
        check("t6_h_rdy", 64'(bus.rq_ready), 64'h2);
        check("t6_h_rsv", 64'(bus.rs_valid), 64'h1);
        check("t6_h_rsd", 64'(bus.rs_rdata), 64'hFFFF_1234);
        nx();
        set_rq(1, 0, 0, 0, 0, 0);
        smp();
        check("t6_i_rsv", 64'(bus.rs_valid), 64'h2);
        check("t6_i_rsd", 64'(bus.rs_rdata), 64'h0000_F00D);
        nx();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 1024 x 32 memory (mem_en/mem_we/mem_addr/mem_wdata/mem_rdata) between two requesters, e.g. the write-channel and read-channel engines of axi4_memory.
- Performs round-robin arbitration with optional burst lock and a lock-length watchdog.
- Tags each accepted read and routes the returned mem_rdata back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 10, memory word-address width
- DATA_WIDTH, 32, memory data width
- RD_LATENCY, 1, cycles from accepted read (mem_en=1, mem_we=0) to valid mem_rdata; legal range 1..4
- MAX_LOCK_BEATS, 16, maximum accepted beats in one locked burst before forced release; minimum 2

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous reset, active-high
- rq_valid  in  2  per-requester request valid (bit i = requester i)
- rq_ready  out  2  per-requester accept; a transfer happens when valid & ready
- rq_we  in  2  per-requester write enable
- rq_lock  in  2  per-requester; 1 = keep grant after this beat
- rq_addr  in  2*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rq_wdata  in  2*DATA_WIDTH  packed write data
- rs_valid  out  2  read-response valid, one-cycle pulse per accepted read
- rs_rdata  out  DATA_WIDTH  read data; qualified by rs_valid
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Reset values: rq_ready=0, rs_valid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. Internal state: state=ARB, last_grant=1 (requester 0 wins first contention), beat_cnt=0, read-tag pipeline cleared.
- Reset mid-operation: in-flight reads are discarded and no rs_valid is issued for them. An active lock is dropped.
- Request path is combinational and zero-latency. grant (one-hot or zero) is computed each cycle. rq_ready = grant. mem_en = |(grant & rq_valid). mem_we, mem_addr and mem_wdata are muxed from the granted requester. When mem_en=0, mem_we=0 and mem_addr/mem_wdata hold 0.
- FSM state ARB:
  - Only one requester valid: it is granted.
  - Both valid: grant the requester != last_grant.
  - On an accepted beat: last_grant <= winner.
  - Accepted beat with rq_lock=1: go to LOCKED, owner <= winner, beat_cnt <= 1.
- FSM state LOCKED:
  - grant = owner only; the other requester sees rq_ready=0 even if the owner is idle (owner may insert bubbles).
  - Each accepted owner beat increments beat_cnt.
  - Owner beat with rq_lock=0 -> ARB.
  - Accepted beat that brings beat_cnt to MAX_LOCK_BEATS -> ARB regardless of rq_lock. The next contended cycle then grants the non-owner.
- Read return:
  - A shift pipeline of depth RD_LATENCY carries {valid, requester id} for each accepted read.
  - At the pipe output, rs_valid[id] is asserted for one cycle and rs_rdata = mem_rdata.
  - rs_rdata is a don't-care but holds its last value when no response.
  - Back-to-back reads from alternating requesters return in issue order with no gaps.
  - Writes produce no response.
- Simultaneous events:
  - A response for requester i and a new accept for requester i in the same cycle are independent.
  - rq_lock is sampled only on accepted beats.
- Requesters must hold valid/addr/wdata/we/lock stable until accepted; the arbiter does not check this.

Decomposition:
- Package mem_arb_pkg:
  - typedef arb_state_e {ARB, LOCKED}
  - typedef req_id_t (1 bit)
  - localparams for default ADDR_WIDTH/DATA_WIDTH
- One sub-module rr_grant2: pure combinational 2-way round-robin picker. Inputs: req[1:0], last_grant, force_owner_en, owner. Output: grant[1:0]. Reused by the future 4-port version.

Test Plan:
- Reset then single requester: after ARESET, req0 write addr 0x005 data 0xDEADBEEF, then req0 read 0x005. Same-cycle mem_en=1, mem_we=1, rq_ready[0]=1 on the write; rs_valid[0] pulses RD_LATENCY cycles after the read with rs_rdata=0xDEADBEEF.
- Contention fairness: both requesters hold valid reads continuously for 8 cycles. Grants alternate 0,1,0,1...; each requester gets exactly 4 rs_valid pulses, returned in issue order.
- Burst lock: req1 issues 4 writes with rq_lock=1,1,1,0 while req0 is continuously valid. rq_ready[0]=0 for all 4 beats; req0 is granted on the cycle after req1's last beat.
- Watchdog: with MAX_LOCK_BEATS=16, req0 holds rq_lock=1 for 20 beats while req1 is valid. After beat 16, req1 is granted for one beat; req0 resumes afterward.
- Reset mid-read: req0 read accepted, ARESET asserted the next cycle. No rs_valid occurs, all outputs are at their reset values, and the first contended grant afterward goes to requester 0.
- Address boundary: write then read addresses 0x000 and 0x3FF (all 1s) from alternating requesters. Each read returns the data written there, with rs_valid on the correct bit.
